// File: rtl/agc_servo_pkg.sv
// Shared types and widths for the AGC servo controller.
package agc_servo_pkg;

   localparam int SCALE_W = 17;
   localparam int OFS_W   = 8;
   localparam int SQ_W    = 24;
   localparam int CNT_W   = 21;
   localparam int STEP_W  = 13;

   localparam logic [SCALE_W-1:0] SCALE_MAX = 17'h1FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST,
      ST_TICK,
      ST_WAIT,
      ST_CALC,
      ST_LOAD,
      ST_APPLY,
      ST_HOLD
   } state_t;

endpackage

// File: rtl/agc_servo_step.sv
// Combinational saturating next-value computation for AGC scale and offset.
// AGC_SERVO_PROPORTIONAL_EN selects an error-proportional scale step instead of a fixed one.
module agc_servo_step
   import agc_servo_pkg::*;
#(
   parameter int SCALE_STEP = 64,
   parameter int SCALE_MIN  = 1024
`ifdef AGC_SERVO_PROPORTIONAL_EN
   ,
   parameter int STEP_SHIFT = 6
`endif
) (
   input  logic        [SCALE_W-1:0] scale,
   input  logic signed [OFS_W-1:0]   offset,
   input  logic        [SQ_W-1:0]    sq,
   input  logic        [CNT_W-1:0]   gt,
   input  logic        [CNT_W-1:0]   lt,
   input  logic        [SQ_W-1:0]    target_lo,
   input  logic        [SQ_W-1:0]    target_hi,
   input  logic        [CNT_W-1:0]   deadband,
   output logic        [SCALE_W-1:0] scale_next,
   output logic signed [OFS_W-1:0]   offset_next,
   output logic                      scale_hit,
   output logic                      ofs_hit
);

   localparam logic [SCALE_W-1:0]      SCALE_MIN_S = SCALE_W'(SCALE_MIN);
   localparam logic signed [OFS_W-1:0] OFS_MIN = {1'b1, {(OFS_W-1){1'b0}}};
   localparam logic signed [OFS_W-1:0] OFS_MAX = {1'b0, {(OFS_W-1){1'b1}}};

   logic              sq_hi, sq_lo;
   logic [STEP_W-1:0] step;

   assign sq_hi = sq > target_hi;
   assign sq_lo = sq < target_lo;

`ifdef AGC_SERVO_PROPORTIONAL_EN
   logic [SQ_W-1:0] err, err_sh;

   always_comb begin
      err    = sq_hi ? (sq - target_hi) : (target_lo - sq);
      err_sh = err >> STEP_SHIFT;
      if (err_sh == '0)
         step = STEP_W'(1);
      else if (err_sh > SQ_W'(4096))
         step = STEP_W'(4096);
      else
         step = err_sh[STEP_W-1:0];
   end
`else
   assign step = STEP_W'(SCALE_STEP);
`endif

   logic [SCALE_W:0] inc_x, floor_x;

   // One extra bit catches the carry past SCALE_MAX and the MIN+step sum.
   assign inc_x   = {1'b0, scale} + (SCALE_W+1)'(step);
   assign floor_x = {1'b0, SCALE_MIN_S} + (SCALE_W+1)'(step);

   always_comb begin
      scale_next = scale;
      if (sq_hi) begin
         if ({1'b0, scale} >= floor_x)
            scale_next = scale - SCALE_W'(step);
         else
            scale_next = SCALE_MIN_S;
      end else if (sq_lo) begin
         if (inc_x[SCALE_W])
            scale_next = SCALE_MAX;
         else
            scale_next = inc_x[SCALE_W-1:0];
      end
   end

   logic [CNT_W:0] gt_x, lt_x, gt_lim, lt_lim;
   logic           ofs_dn, ofs_up;

   assign gt_x   = {1'b0, gt};
   assign lt_x   = {1'b0, lt};
   assign gt_lim = gt_x + {1'b0, deadband};
   assign lt_lim = lt_x + {1'b0, deadband};
   assign ofs_dn = gt_x > lt_lim;
   assign ofs_up = lt_x > gt_lim;

   always_comb begin
      offset_next = offset;
      if (ofs_dn) begin
         if (offset != OFS_MIN)
            offset_next = offset - 8'sd1;
      end else if (ofs_up) begin
         if (offset != OFS_MAX)
            offset_next = offset + 8'sd1;
      end
   end

   assign scale_hit = sq_hi | sq_lo;
   assign ofs_hit   = ofs_dn | ofs_up;

endmodule

// File: rtl/agc_servo.sv
// Closed-loop AGC servo: requests a measurement, reads the accumulators, steps scale/offset.
// Define AGC_SERVO_PROPORTIONAL_EN for an error-proportional scale step.
module agc_servo
   import agc_servo_pkg::*;
#(
   parameter int SCALE_STEP     = 64,
   parameter int SCALE_MIN      = 1024,
   parameter int TIMEOUT_CYCLES = 262144
`ifdef AGC_SERVO_PROPORTIONAL_EN
   ,
   parameter int STEP_SHIFT     = 6
`endif
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      en_i,
   input  logic        [SQ_W-1:0]    target_lo_i,
   input  logic        [SQ_W-1:0]    target_hi_i,
   input  logic        [CNT_W-1:0]   ofs_deadband_i,
   input  logic        [SCALE_W-1:0] scale_init_i,
   input  logic signed [OFS_W-1:0]   offset_init_i,
   input  logic        [15:0]        holdoff_i,
   input  logic        [SQ_W-1:0]    sq_accum_i,
   input  logic        [CNT_W-1:0]   gt_accum_i,
   input  logic        [CNT_W-1:0]   lt_accum_i,
   input  logic                      agc_done_i,
   output logic                      agc_rst_o,
   output logic                      agc_tick_o,
   output logic        [SCALE_W-1:0] agc_scale_o,
   output logic signed [OFS_W-1:0]   agc_offset_o,
   output logic                      agc_scale_ce_o,
   output logic                      agc_offset_ce_o,
   output logic                      agc_apply_o,
   output logic                      locked_o,
   output logic                      timeout_o,
   output logic                      busy_o
);

   localparam int                   WAIT_W      = $clog2(TIMEOUT_CYCLES);
   localparam logic [WAIT_W-1:0]    WAIT_TERM   = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SCALE_W-1:0]   SCALE_MIN_S = SCALE_W'(SCALE_MIN);

   state_t              state, state_n;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [15:0]         hold_cnt;
   logic                wait_term;

   logic        [SQ_W-1:0]  sq_p1;
   logic        [CNT_W-1:0] gt_p1, lt_p1;
   logic        [SCALE_W-1:0] scale_next;
   logic signed [OFS_W-1:0]   offset_next;
   logic                      scale_hit, ofs_hit;

   assign wait_term = (wait_cnt == WAIT_TERM);
   assign busy_o    = (state != ST_IDLE);

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (en_i) state_n = ST_RST;
         ST_RST:   state_n = ST_TICK;
         ST_TICK:  state_n = ST_WAIT;
         ST_WAIT: begin
            if (agc_done_i)
               state_n = ST_CALC;
            else if (wait_term)
               state_n = ST_IDLE;
         end
         ST_CALC:  state_n = ST_LOAD;
         ST_LOAD:  state_n = ST_APPLY;
         ST_APPLY: state_n = ST_HOLD;
         ST_HOLD:  if (hold_cnt == holdoff_i) state_n = en_i ? ST_RST : ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         hold_cnt        <= '0;
         agc_rst_o       <= 1'b0;
         agc_tick_o      <= 1'b0;
         agc_scale_ce_o  <= 1'b0;
         agc_offset_ce_o <= 1'b0;
         agc_apply_o     <= 1'b0;
         agc_scale_o     <= '0;
         agc_offset_o    <= '0;
         locked_o        <= 1'b0;
         timeout_o       <= 1'b0;
      end else begin
         state           <= state_n;
         // Strobes decode the next state so each is a clean flop output.
         agc_rst_o       <= (state_n == ST_RST);
         agc_tick_o      <= (state_n == ST_TICK);
         agc_scale_ce_o  <= (state_n == ST_LOAD);
         agc_offset_ce_o <= (state_n == ST_LOAD);
         agc_apply_o     <= (state_n == ST_APPLY);
         wait_cnt        <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         hold_cnt        <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;

         if (state == ST_IDLE && en_i) begin
            agc_scale_o  <= (scale_init_i < SCALE_MIN_S) ? SCALE_MIN_S : scale_init_i;
            agc_offset_o <= offset_init_i;
            locked_o     <= 1'b0;
         end
         if (state == ST_WAIT && !agc_done_i && wait_term) begin
            timeout_o <= 1'b1;
            locked_o  <= 1'b0;
         end
         if (state == ST_CALC) begin
            agc_scale_o  <= scale_next;
            agc_offset_o <= offset_next;
            locked_o     <= !(scale_hit || ofs_hit);
         end
      end
   end

   // Accumulator capture stage: data only, no reset needed.
   always_ff @(posedge clk_i) begin
      if (state == ST_WAIT && agc_done_i) begin
         sq_p1 <= sq_accum_i;
         gt_p1 <= gt_accum_i;
         lt_p1 <= lt_accum_i;
      end
   end

   agc_servo_step #(
      .SCALE_STEP (SCALE_STEP),
      .SCALE_MIN  (SCALE_MIN)
`ifdef AGC_SERVO_PROPORTIONAL_EN
      ,
      .STEP_SHIFT (STEP_SHIFT)
`endif
   ) u_step (
      .scale       (agc_scale_o),
      .offset      (agc_offset_o),
      .sq          (sq_p1),
      .gt          (gt_p1),
      .lt          (lt_p1),
      .target_lo   (target_lo_i),
      .target_hi   (target_hi_i),
      .deadband    (ofs_deadband_i),
      .scale_next  (scale_next),
      .offset_next (offset_next),
      .scale_hit   (scale_hit),
      .ofs_hit     (ofs_hit)
   );

endmodule

// File: tb/tb_agc_servo.sv
// Directed testbench for agc_servo (default build, short WAIT timeout).
module tb_agc_servo;

   localparam int TO = 64;

   logic               clk = 1'b0;
   logic               rst_i, en_i, agc_done_i;
   logic [23:0]        target_lo_i, target_hi_i, sq_accum_i;
   logic [20:0]        ofs_deadband_i, gt_accum_i, lt_accum_i;
   logic [16:0]        scale_init_i;
   logic signed [7:0]  offset_init_i;
   logic [15:0]        holdoff_i;
   logic               agc_rst_o, agc_tick_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o;
   logic [16:0]        agc_scale_o;
   logic signed [7:0]  agc_offset_o;
   logic               locked_o, timeout_o, busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   agc_servo #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .en_i            (en_i),
      .target_lo_i     (target_lo_i),
      .target_hi_i     (target_hi_i),
      .ofs_deadband_i  (ofs_deadband_i),
      .scale_init_i    (scale_init_i),
      .offset_init_i   (offset_init_i),
      .holdoff_i       (holdoff_i),
      .sq_accum_i      (sq_accum_i),
      .gt_accum_i      (gt_accum_i),
      .lt_accum_i      (lt_accum_i),
      .agc_done_i      (agc_done_i),
      .agc_rst_o       (agc_rst_o),
      .agc_tick_o      (agc_tick_o),
      .agc_scale_o     (agc_scale_o),
      .agc_offset_o    (agc_offset_o),
      .agc_scale_ce_o  (agc_scale_ce_o),
      .agc_offset_ce_o (agc_offset_ce_o),
      .agc_apply_o     (agc_apply_o),
      .locked_o        (locked_o),
      .timeout_o       (timeout_o),
      .busy_o          (busy_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (agc_tick_o) begin
            found = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Returns with the DUT in CALC (one cycle after the done pulse).
   task automatic do_iter(input logic [23:0] sq, input logic [20:0] gt, input logic [20:0] lt,
                          output bit found);
      wait_tick(found);
      if (!found) return;
      step();
      sq_accum_i = sq;
      gt_accum_i = gt;
      lt_accum_i = lt;
      agc_done_i = 1'b1;
      step();
      agc_done_i = 1'b0;
   endtask

   task automatic restart(input logic [16:0] s_init, input logic signed [7:0] o_init);
      rst_i = 1'b1;
      en_i  = 1'b0;
      scale_init_i  = s_init;
      offset_init_i = o_init;
      step();
      step();
      rst_i = 1'b0;
      en_i  = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      n_cmp++;
      if ({agc_rst_o, agc_tick_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
           locked_o, timeout_o, busy_o} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 00000000", {agc_rst_o, agc_tick_o,
                  agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, locked_o, timeout_o, busy_o});
      end
      n_cmp++;
      if (agc_scale_o !== 17'd0 || agc_offset_o !== 8'sd0) begin
         n_bad++;
         $display("FAIL reset_values: got scale %0d offset %0d want 0 0", agc_scale_o, agc_offset_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_basic();
      bit found;
      restart(17'd20000, 8'sd0);
      do_iter(24'd5000, 21'd100, 21'd100, found);
      n_cmp++;
      if (found !== 1'b1) begin n_bad++; $display("FAIL basic_tick: got %0d want 1", found); end
      n_cmp++;
      if (agc_scale_ce_o !== 1'b0) begin n_bad++; $display("FAIL basic_ce_early: got %b want 0", agc_scale_ce_o); end
      step();
      n_cmp++;
      if ({agc_scale_ce_o, agc_offset_ce_o, agc_apply_o} !== 3'b110) begin
         n_bad++;
         $display("FAIL basic_ce: got %b want 110", {agc_scale_ce_o, agc_offset_ce_o, agc_apply_o});
      end
      n_cmp++;
      if (agc_scale_o !== 17'd19936 || agc_offset_o !== 8'sd0 || locked_o !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_value: got scale %0d ofs %0d lock %b want 19936 0 0",
                  agc_scale_o, agc_offset_o, locked_o);
      end
      step();
      n_cmp++;
      if ({agc_scale_ce_o, agc_offset_ce_o, agc_apply_o} !== 3'b001) begin
         n_bad++;
         $display("FAIL basic_apply: got %b want 001", {agc_scale_ce_o, agc_offset_ce_o, agc_apply_o});
      end
   endtask

   task automatic test_locked();
      bit found;
      int n;
      do_iter(24'd1500, 21'd100, 21'd100, found);
      step();
      n_cmp++;
      if (found !== 1'b1 || agc_scale_o !== 17'd19936 || agc_offset_o !== 8'sd0 || locked_o !== 1'b1) begin
         n_bad++;
         $display("FAIL locked_value: got found %0d scale %0d ofs %0d lock %b want 1 19936 0 1",
                  found, agc_scale_o, agc_offset_o, locked_o);
      end
      step();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n++;
         if (agc_rst_o) break;
      end
      n_cmp++;
      if (n !== 5) begin n_bad++; $display("FAIL holdoff3_gap: got %0d want 5", n); end
   endtask

   task automatic test_scale_sat();
      bit found;
      int n;
      holdoff_i = 16'd0;
      restart(17'd1050, 8'sd0);
      do_iter(24'd5000, 21'd100, 21'd100, found);
      step();
      n_cmp++;
      if (found !== 1'b1 || agc_scale_o !== 17'd1024) begin
         n_bad++;
         $display("FAIL scale_floor: got %0d want 1024", agc_scale_o);
      end
      step();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n++;
         if (agc_rst_o) break;
      end
      n_cmp++;
      if (n !== 2) begin n_bad++; $display("FAIL holdoff0_gap: got %0d want 2", n); end
      do_iter(24'd5000, 21'd100, 21'd100, found);
      step();
      n_cmp++;
      if (agc_scale_o !== 17'd1024) begin n_bad++; $display("FAIL scale_floor_again: got %0d want 1024", agc_scale_o); end
      restart(17'd131060, 8'sd0);
      do_iter(24'd500, 21'd100, 21'd100, found);
      step();
      n_cmp++;
      if (agc_scale_o !== 17'd131071) begin n_bad++; $display("FAIL scale_ceiling: got %0d want 131071", agc_scale_o); end
      restart(17'd100, 8'sd0);
      wait_tick(found);
      n_cmp++;
      if (agc_scale_o !== 17'd1024) begin n_bad++; $display("FAIL scale_init_clamp: got %0d want 1024", agc_scale_o); end
      holdoff_i = 16'd3;
   endtask

   task automatic test_offset_sat();
      bit found;
      restart(17'd20000, -8'sd128);
      do_iter(24'd1500, 21'd500, 21'd0, found);
      step();
      n_cmp++;
      if (agc_offset_o !== -8'sd128 || agc_scale_o !== 17'd20000 || locked_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ofs_floor: got ofs %0d scale %0d lock %b want -128 20000 0",
                  agc_offset_o, agc_scale_o, locked_o);
      end
      restart(17'd20000, 8'sd127);
      do_iter(24'd1500, 21'd0, 21'd500, found);
      step();
      n_cmp++;
      if (agc_offset_o !== 8'sd127) begin n_bad++; $display("FAIL ofs_ceiling: got %0d want 127", agc_offset_o); end
      restart(17'd20000, 8'sd0);
      do_iter(24'd1500, 21'd500, 21'd0, found);
      step();
      n_cmp++;
      if (agc_offset_o !== -8'sd1) begin n_bad++; $display("FAIL ofs_down: got %0d want -1", agc_offset_o); end
      do_iter(24'd1500, 21'd110, 21'd100, found);
      step();
      n_cmp++;
      if (agc_offset_o !== -8'sd1 || locked_o !== 1'b1) begin
         n_bad++;
         $display("FAIL ofs_deadband_edge: got ofs %0d lock %b want -1 1", agc_offset_o, locked_o);
      end
   endtask

   task automatic test_timeout();
      bit found;
      restart(17'd20000, 8'sd0);
      wait_tick(found);
      step();
      for (int i = 0; i < TO - 1; i++) step();
      n_cmp++;
      if ({busy_o, timeout_o} !== 2'b10) begin
         n_bad++;
         $display("FAIL timeout_early: got busy/to %b want 10", {busy_o, timeout_o});
      end
      step();
      en_i = 1'b0;
      n_cmp++;
      if ({busy_o, timeout_o, locked_o} !== 3'b010) begin
         n_bad++;
         $display("FAIL timeout_fire: got busy/to/lock %b want 010", {busy_o, timeout_o, locked_o});
      end
      restart(17'd20000, 8'sd0);
      wait_tick(found);
      step();
      for (int i = 0; i < TO - 1; i++) step();
      sq_accum_i = 24'd5000;
      gt_accum_i = 21'd100;
      lt_accum_i = 21'd100;
      agc_done_i = 1'b1;
      step();
      agc_done_i = 1'b0;
      n_cmp++;
      if ({busy_o, timeout_o} !== 2'b10) begin
         n_bad++;
         $display("FAIL timeout_done_wins: got busy/to %b want 10", {busy_o, timeout_o});
      end
      step();
      n_cmp++;
      if (agc_scale_ce_o !== 1'b1 || agc_scale_o !== 17'd19936) begin
         n_bad++;
         $display("FAIL timeout_done_load: got ce %b scale %0d want 1 19936", agc_scale_ce_o, agc_scale_o);
      end
   endtask

   task automatic test_en_drop();
      bit found;
      int n_apply, n_rst;
      restart(17'd20000, 8'sd0);
      wait_tick(found);
      step();
      en_i = 1'b0;
      step();
      step();
      sq_accum_i = 24'd5000;
      agc_done_i = 1'b1;
      step();
      agc_done_i = 1'b0;
      n_apply = 0;
      n_rst = 0;
      for (int i = 0; i < 30; i++) begin
         if (agc_apply_o) n_apply++;
         if (agc_rst_o) n_rst++;
         step();
      end
      n_cmp++;
      if (n_apply !== 1 || n_rst !== 0 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL en_drop: got apply %0d rst %0d busy %b want 1 0 0", n_apply, n_rst, busy_o);
      end
   endtask

   task automatic test_rst_in_load();
      bit found;
      restart(17'd20000, 8'sd5);
      do_iter(24'd5000, 21'd100, 21'd100, found);
      step();
      n_cmp++;
      if (agc_scale_ce_o !== 1'b1) begin n_bad++; $display("FAIL rst_load_pre: got %b want 1", agc_scale_ce_o); end
      rst_i = 1'b1;
      step();
      n_cmp++;
      if ({agc_rst_o, agc_tick_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o,
           locked_o, timeout_o, busy_o} !== 8'h00 || agc_scale_o !== 17'd0 || agc_offset_o !== 8'sd0) begin
         n_bad++;
         $display("FAIL rst_load: got flags %b scale %0d ofs %0d want 0 0 0", {agc_rst_o, agc_tick_o,
                  agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, locked_o, timeout_o, busy_o},
                  agc_scale_o, agc_offset_o);
      end
      rst_i = 1'b0;
      en_i  = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      en_i = 1'b0;
      agc_done_i = 1'b0;
      target_lo_i = 24'd1000;
      target_hi_i = 24'd2000;
      ofs_deadband_i = 21'd10;
      scale_init_i = 17'd20000;
      offset_init_i = 8'sd0;
      holdoff_i = 16'd3;
      sq_accum_i = '0;
      gt_accum_i = '0;
      lt_accum_i = '0;
      test_reset();
      test_basic();
      test_locked();
      test_scale_sat();
      test_offset_sat();
      test_timeout();
      test_en_drop();
      test_rst_in_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
